// File: rtl/dtc_stream_eval.sv
// Streaming evaluator for an external combinational classifier: it registers each sample, captures the decision and keeps saturating statistics.
// Optional confusion-matrix counters are built when DTC_EVAL_CONFUSION_EN is defined.
module dtc_stream_eval #(
  parameter int FEAT_W = 13,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FEAT_W-1:0] in_feat,
  input  logic              in_label,
  output logic [FEAT_W-1:0] cls_inp,
  input  logic              cls_outp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_pred,
  output logic              out_match,
  input  logic              clear,
  output logic [CNT_W-1:0]  sample_cnt,
  output logic [CNT_W-1:0]  err_cnt,
`ifdef DTC_EVAL_CONFUSION_EN
  output logic [CNT_W-1:0]  tp_cnt,
  output logic [CNT_W-1:0]  fp_cnt,
  output logic [CNT_W-1:0]  tn_cnt,
  output logic [CNT_W-1:0]  fn_cnt,
`endif
  output logic [1:0]        state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // valid never waits on ready; in_ready in HOLD follows out_ready combinationally.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   label_q;
  logic   accept;
  logic   eval_fire;
  logic   mismatch;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  assign state     = state_q;
  assign accept    = in_valid & in_ready;
  assign eval_fire = (state_q == EVAL);
  assign mismatch  = (cls_outp != label_q);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = EVAL;
      EVAL:    state_d = HOLD;
      HOLD:    if (out_ready) state_d = in_valid ? EVAL : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: in_ready = 1'b1;
      HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: ;
    endcase
  end

  // cls_inp only moves on accept so the classifier sees a stable vector in EVAL.
  always_ff @(posedge clk) begin
    if (rst) begin
      cls_inp   <= '0;
      label_q   <= 1'b0;
      out_pred  <= 1'b0;
      out_match <= 1'b0;
    end else begin
      if (accept) begin
        cls_inp <= in_feat;
        label_q <= in_label;
      end
      if (eval_fire) begin
        out_pred  <= cls_outp;
        out_match <= ~mismatch;
      end
    end
  end

  // clear wins over the EVAL increment of the same edge.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sample_cnt <= '0;
      err_cnt    <= '0;
    end else if (eval_fire) begin
      sample_cnt <= sat_inc(sample_cnt);
      if (mismatch) err_cnt <= sat_inc(err_cnt);
    end
  end

`ifdef DTC_EVAL_CONFUSION_EN
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      tp_cnt <= '0;
      fp_cnt <= '0;
      tn_cnt <= '0;
      fn_cnt <= '0;
    end else if (eval_fire) begin
      case ({cls_outp, label_q})
        2'b11:   tp_cnt <= sat_inc(tp_cnt);
        2'b10:   fp_cnt <= sat_inc(fp_cnt);
        2'b00:   tn_cnt <= sat_inc(tn_cnt);
        default: fn_cnt <= sat_inc(fn_cnt);
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_dtc_stream_eval.sv
// Bench for dtc_stream_eval: two instances (CNT_W=16 and CNT_W=4) share stimulus and are checked against a transaction-level model.
// Connects the confusion counters when DTC_EVAL_CONFUSION_EN is defined.
module tb_dtc_stream_eval;

  localparam int FW = 13;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, in_valid, in_label, out_ready, clear;
  logic [FW-1:0] in_feat;

  logic          in_ready_a, out_valid_a, out_pred_a, out_match_a, cls_outp_a;
  logic [FW-1:0] cls_inp_a;
  logic [15:0]   sample_cnt_a, err_cnt_a;
  logic [1:0]    state_a;
  logic          in_ready_b, out_valid_b, out_pred_b, out_match_b, cls_outp_b;
  logic [FW-1:0] cls_inp_b;
  logic [3:0]    sample_cnt_b, err_cnt_b;
  logic [1:0]    state_b;
`ifdef DTC_EVAL_CONFUSION_EN
  logic [15:0]   tp_a, fp_a, tn_a, fn_a;
  logic [3:0]    tp_b, fp_b, tn_b, fn_b;
`endif

  // Classifier model: odd number of set feature bits -> class 1.
  function automatic logic classify(input logic [FW-1:0] f);
    return ($countones(f) % 2) == 1;
  endfunction

  assign cls_outp_a = classify(cls_inp_a);
  assign cls_outp_b = classify(cls_inp_b);

  dtc_stream_eval #(.FEAT_W(FW), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_feat(in_feat), .in_label(in_label), .cls_inp(cls_inp_a), .cls_outp(cls_outp_a),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_pred(out_pred_a),
    .out_match(out_match_a), .clear(clear), .sample_cnt(sample_cnt_a), .err_cnt(err_cnt_a),
`ifdef DTC_EVAL_CONFUSION_EN
    .tp_cnt(tp_a), .fp_cnt(fp_a), .tn_cnt(tn_a), .fn_cnt(fn_a),
`endif
    .state(state_a)
  );

  dtc_stream_eval #(.FEAT_W(FW), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_feat(in_feat), .in_label(in_label), .cls_inp(cls_inp_b), .cls_outp(cls_outp_b),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_pred(out_pred_b),
    .out_match(out_match_b), .clear(clear), .sample_cnt(sample_cnt_b), .err_cnt(err_cnt_b),
`ifdef DTC_EVAL_CONFUSION_EN
    .tp_cnt(tp_b), .fp_cnt(fp_b), .tn_cnt(tn_b), .fn_cnt(fn_b),
`endif
    .state(state_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: raw event counts since clear, saturated only when compared.
  logic          m_busy, m_held, m_pend_pred, m_pend_label;
  logic [FW-1:0] m_feat;
  logic [1:0]    exp_q[$];
  int            m_samp, m_err, m_tp, m_fp, m_tn, m_fn;
  int            n_accepts, n_results;

  function automatic int sat(input int v, input int w);
    return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_held = 0; m_feat = '0;
    m_pend_pred = 0; m_pend_label = 0;
    exp_q.delete();
    m_samp = 0; m_err = 0; m_tp = 0; m_fp = 0; m_tn = 0; m_fn = 0;
  endtask

  // One clock: check outputs against the model, advance the model, cross the edge.
  task automatic tick();
    logic exp_ready;
    logic [1:0] exp_state;
    #1;
    exp_ready = !m_busy && (!m_held || out_ready);
    exp_state = m_busy ? 2'd1 : (m_held ? 2'd2 : 2'd0);
    chk("in_ready_a", in_ready_a, exp_ready);
    chk("in_ready_b", in_ready_b, exp_ready);
    chk("out_valid_a", out_valid_a, m_held);
    chk("out_valid_b", out_valid_b, m_held);
    chk("state_a", state_a, exp_state);
    chk("cls_inp_a", cls_inp_a, m_feat);
    chk("cls_inp_b", cls_inp_b, m_feat);
    if (m_held && exp_q.size() > 0) begin
      chk("out_pred_a", out_pred_a, exp_q[0][1]);
      chk("out_match_a", out_match_a, exp_q[0][0]);
      chk("out_pred_b", out_pred_b, exp_q[0][1]);
      chk("out_match_b", out_match_b, exp_q[0][0]);
    end
    chk("sample_cnt_a", sample_cnt_a, sat(m_samp, 16));
    chk("err_cnt_a", err_cnt_a, sat(m_err, 16));
    chk("sample_cnt_b", sample_cnt_b, sat(m_samp, 4));
    chk("err_cnt_b", err_cnt_b, sat(m_err, 4));
`ifdef DTC_EVAL_CONFUSION_EN
    chk("tp_a", tp_a, sat(m_tp, 16)); chk("fp_a", fp_a, sat(m_fp, 16));
    chk("tn_a", tn_a, sat(m_tn, 16)); chk("fn_a", fn_a, sat(m_fn, 16));
    chk("tp_b", tp_b, sat(m_tp, 4));  chk("fp_b", fp_b, sat(m_fp, 4));
    chk("tn_b", tn_b, sat(m_tn, 4));  chk("fn_b", fn_b, sat(m_fn, 4));
`endif
    if (rst) begin
      model_reset();
    end else begin
      if (m_held && out_ready) begin
        void'(exp_q.pop_front());
        n_results++;
      end
      if (clear) begin
        m_samp = 0; m_err = 0; m_tp = 0; m_fp = 0; m_tn = 0; m_fn = 0;
      end else if (m_busy) begin
        m_samp++;
        if (m_pend_pred != m_pend_label) m_err++;
        if (m_pend_pred && m_pend_label) m_tp++;
        if (m_pend_pred && !m_pend_label) m_fp++;
        if (!m_pend_pred && !m_pend_label) m_tn++;
        if (!m_pend_pred && m_pend_label) m_fn++;
      end
      m_held = m_busy ? 1'b1 : (m_held && !out_ready);
      if (exp_ready && in_valid) begin
        m_feat       = in_feat;
        m_pend_pred  = classify(in_feat);
        m_pend_label = in_label;
        exp_q.push_back({m_pend_pred, m_pend_pred == in_label});
        m_busy = 1;
        n_accepts++;
      end else begin
        m_busy = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [FW-1:0] feat;
    logic          label;
    logic          exp_pred;
    logic          exp_match;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input vec_t v, input int idx);
    int w;
    in_valid = 1; in_feat = v.feat; in_label = v.label; out_ready = 0;
    tick();
    in_valid = 0;
    w = 0;
    while (!out_valid_a && w < 10) begin
      tick();
      w++;
    end
    chk($sformatf("vec%0d_latency", idx), w + 1, 2);
    chk($sformatf("vec%0d_pred", idx), out_pred_a, v.exp_pred);
    chk($sformatf("vec%0d_match", idx), out_match_a, v.exp_match);
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask

  logic [FW-1:0] snap_feat;
  logic          snap_pred, snap_match;
  int            acc0;

  initial begin
    vecs[0] = '{13'h1000, 1'b1, 1'b1, 1'b1};
    vecs[1] = '{13'h1000, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{13'h0003, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{13'h0007, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{13'h1fff, 1'b1, 1'b1, 1'b1};
    vecs[5] = '{13'h0000, 1'b1, 1'b0, 1'b0};

    rst = 1; in_valid = 0; in_label = 0; in_feat = '0; out_ready = 0; clear = 0;
    n_accepts = 0; n_results = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    chk("reset_in_ready", in_ready_a, 1);
    chk("reset_out_valid", out_valid_a, 0);
    chk("reset_cls_inp", cls_inp_a, 0);
    chk("reset_sample_cnt", sample_cnt_a, 0);
    tick();

    // Directed table
    run_vec(vecs[0], 0);
    chk("first_sample_cnt", sample_cnt_a, 1);
    chk("first_err_cnt", err_cnt_a, 0);
    run_vec(vecs[1], 1);
    chk("mismatch_err_cnt", err_cnt_a, 1);
`ifdef DTC_EVAL_CONFUSION_EN
    chk("mismatch_fp_cnt", fp_a, 1);
`endif
    for (int i = 2; i < 6; i++) run_vec(vecs[i], i);

    // Backpressure: result and features must hold for 5 stalled cycles
    in_valid = 1; in_feat = 13'h0a5c; in_label = 1; out_ready = 0;
    tick();
    in_feat = 13'h1234;
    tick();
    snap_feat = cls_inp_a; snap_pred = out_pred_a; snap_match = out_match_a;
    acc0 = sample_cnt_a;
    repeat (5) tick();
    chk("stall_out_valid", out_valid_a, 1);
    chk("stall_in_ready", in_ready_a, 0);
    chk("stall_cls_inp", cls_inp_a, 13'h0a5c);
    chk("stall_pred", out_pred_a, classify(13'h0a5c));
    chk("stall_match", out_match_a, classify(13'h0a5c) == 1'b1);
    chk("stall_cnt", sample_cnt_a, acc0);
    in_valid = 0; out_ready = 1;
    tick();

    // Back-to-back: 8 samples in 16 cycles
    clear = 1; tick(); clear = 0;
    acc0 = n_accepts;
    in_valid = 1; out_ready = 1;
    for (int i = 0; i < 16; i++) begin
      in_feat = FW'($urandom_range(0, 8191)); in_label = 1'($urandom_range(0, 1));
      tick();
    end
    in_valid = 0;
    chk("b2b_accepts", n_accepts - acc0, 8);
    chk("b2b_sample_cnt", sample_cnt_a, 8);
    tick();

    // Saturation on the CNT_W=4 instance
    clear = 1; tick(); clear = 0;
    in_valid = 1; out_ready = 1;
    for (int i = 0; i < 40; i++) begin
      in_feat = FW'($urandom_range(0, 8191)); in_label = ~classify(in_feat);
      tick();
    end
    in_valid = 0;
    chk("sat_sample_b", sample_cnt_b, 15);
    chk("sat_err_b", err_cnt_b, 15);
    chk("sat_sample_a", sample_cnt_a, 20);
    tick();
    in_valid = 1; in_feat = 13'h0001; in_label = 0;
    tick();
    in_valid = 0; clear = 1;
    tick();
    clear = 0;
    chk("clear_eval_sample_b", sample_cnt_b, 0);
    chk("clear_eval_err_b", err_cnt_b, 0);
    chk("clear_eval_sample_a", sample_cnt_a, 0);
    chk("clear_eval_out_valid", out_valid_a, 1);
    tick();

    // Reset during EVAL aborts the sample
    in_valid = 1; in_feat = 13'h0001; in_label = 0; out_ready = 0;
    tick();
    in_valid = 0; rst = 1;
    tick();
    rst = 0;
    chk("rst_eval_state", state_a, 0);
    chk("rst_eval_out_valid", out_valid_a, 0);
    chk("rst_eval_in_ready", in_ready_a, 1);
    chk("rst_eval_sample_cnt", sample_cnt_a, 0);
    chk("rst_eval_err_cnt", err_cnt_a, 0);
    out_ready = 1;
    repeat (3) tick();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_feat   = FW'($urandom_range(0, 8191));
      in_label  = 1'($urandom_range(0, 1));
      clear     = ($urandom_range(0, 39) == 0);
      rst       = ($urandom_range(0, 149) == 0);
      tick();
    end
    rst = 0; clear = 0; in_valid = 0; out_ready = 1;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
